// File: rtl/layer_mac_sched_pkg.sv
// Shared types and helpers for the fully-connected layer MAC sequencer.
package layer_mac_sched_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_X, BIAS, MAC, DRAIN, OUTPUT} state_t;

  // Address width for a range of n entries, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_mac_sched_cnt.sv
// Modulo-LIMIT up-counter with synchronous clear; wrap flags the last value.
module layer_mac_sched_cnt #(
  parameter int LIMIT = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  assign wrap = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= wrap ? '0 : count + W'(1);
  end

endmodule

// File: rtl/layer_mac_sched.sv
// Control sequencer for one FC layer: loads X, then walks the shared MAC
// through M neurons, presenting each clamped result over valid/ready.
module layer_mac_sched
  import layer_mac_sched_pkg::*;
#(
  parameter int M  = 5,
  parameter int N  = 2,
  parameter int XW = width_of(N),
  parameter int WW = width_of(M * N),
  parameter int BW = width_of(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          wr_en_x,
  output logic [XW-1:0] addr_x,
  output logic [WW-1:0] addr_w,
  output logic [BW-1:0] addr_b,
  output logic          ld_bias,
  output logic          en_acc,
  output logic          en_relu
);

  localparam logic [WW-1:0] W_LAST = WW'(M * N - 1);

  state_t        state, state_nx;
  logic [XW-1:0] k;
  logic [BW-1:0] j;
  logic [WW-1:0] wptr;
  logic          k_en, k_clr, k_wrap;
  logic          j_wrap;
  logic          hs_in, hs_out;

  assign hs_in  = s_valid & s_ready;
  assign hs_out = m_valid & m_ready;
  assign k_en   = hs_in | (state == MAC);
  assign k_clr  = (state == BIAS);

  // k counts input writes in LOAD_X and read indices in MAC.
  layer_mac_sched_cnt #(.LIMIT(N), .W(XW)) u_k (
    .clk   (clk),
    .reset (reset),
    .en    (k_en),
    .clr   (k_clr),
    .count (k),
    .wrap  (k_wrap)
  );

  layer_mac_sched_cnt #(.LIMIT(M), .W(BW)) u_j (
    .clk   (clk),
    .reset (reset),
    .en    (hs_out),
    .clr   (1'b0),
    .count (j),
    .wrap  (j_wrap)
  );

  // Weight pointer runs linearly over all M*N weights across the vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                wptr <= '0;
    else if (hs_out && j_wrap) wptr <= '0;
    else if (state == MAC)     wptr <= (wptr == W_LAST) ? '0 : wptr + WW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Strobes lag address issue by one cycle to match the registered memory reads.
  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    ld_bias  = 1'b0;
    en_acc   = 1'b0;
    en_relu  = 1'b0;
    case (state)
      IDLE:   state_nx = LOAD_X;
      LOAD_X: begin
        s_ready = 1'b1;
        if (s_valid && k_wrap) state_nx = BIAS;
      end
      BIAS:   state_nx = MAC;
      MAC: begin
        ld_bias = (k == '0);
        en_acc  = (k != '0);
        if (k_wrap) state_nx = DRAIN;
      end
      DRAIN: begin
        en_acc   = 1'b1;
        en_relu  = 1'b1;
        state_nx = OUTPUT;
      end
      OUTPUT: begin
        m_valid = 1'b1;
        m_last  = j_wrap;
        if (m_ready) state_nx = j_wrap ? LOAD_X : BIAS;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign wr_en_x = hs_in;
  assign addr_x  = k;
  assign addr_w  = wptr;
  assign addr_b  = j;

endmodule

// File: tb/tb_layer_mac_sched.sv
// Bench for layer_mac_sched: scoreboarded strobes/results plus directed timing checks.
module tb_layer_mac_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0, m_ready = 1'b0;
  logic       s_ready, m_valid, m_last, wr_en_x, ld_bias, en_acc, en_relu;
  logic [0:0] addr_x;
  logic [3:0] addr_w;
  logic [2:0] addr_b;

  logic       s_valid2 = 1'b1, m_ready2 = 1'b1;
  logic       s_ready2, m_valid2, m_last2, wr2, ld2, acc2, relu2;
  logic [0:0] ax2, aw2, ab2;

  int         n_cmp = 0, n_bad = 0, cyc = 0;
  logic       ignore = 1'b0, done2 = 1'b0;
  logic [11:0] sq[$];
  logic [3:0]  rq[$];
  int          hs_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_mac_sched #(.M(5), .N(2)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .wr_en_x(wr_en_x),
    .addr_x(addr_x), .addr_w(addr_w), .addr_b(addr_b), .ld_bias(ld_bias),
    .en_acc(en_acc), .en_relu(en_relu)
  );

  layer_mac_sched #(.M(1), .N(1)) dut_small (
    .clk(clk), .reset(reset), .s_valid(s_valid2), .s_ready(s_ready2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_last(m_last2), .wr_en_x(wr2),
    .addr_x(ax2), .addr_w(aw2), .addr_b(ab2), .ld_bias(ld2),
    .en_acc(acc2), .en_relu(relu2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] cur();
    return {s_ready, wr_en_x, ld_bias, en_acc, en_relu, m_valid, m_last, addr_x, addr_w, addr_b};
  endfunction

  function automatic logic [6:0] cur2();
    return {s_ready2, wr2, ld2, acc2, relu2, m_valid2, m_last2};
  endfunction

  function automatic logic [11:0] sv(input logic wr, ld, acc, relu, input int ax, aw, ab);
    return {wr, ld, acc, relu, ax[0], aw[3:0], ab[2:0]};
  endfunction

  // Monitor samples one time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (!ignore) begin
      if (wr_en_x | ld_bias | en_acc | en_relu) begin
        if (sq.size() == 0) chk("strobe_extra", 32'({wr_en_x, ld_bias, en_acc, en_relu, addr_x, addr_w, addr_b}), 32'(0));
        else chk("strobe", 32'({wr_en_x, ld_bias, en_acc, en_relu, addr_x, addr_w, addr_b}), 32'(sq.pop_front()));
      end
      if (m_valid && m_ready) begin
        hs_cyc.push_back(cyc);
        if (rq.size() == 0) chk("result_extra", 32'({1'b1, m_last, addr_b}), 32'(0));
        else chk("result", 32'({m_last, addr_b}), 32'(rq.pop_front()));
      end
    end
  end

  initial begin
    logic [6:0] t2 [6];
    t2 = '{7'b1100000, 7'b0000000, 7'b0010000, 7'b0001100, 7'b0000011, 7'b1100000};
    @(negedge reset);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("n1m1_seq%0d", i), 32'(cur2()), 32'(t2[i]));
    end
    done2 = 1'b1;
  end

  initial begin
    logic [14:0] tab [12];
    tab = '{15'b1100000_0_0000_000, 15'b1100000_1_0000_000, 15'b0000000_0_0000_000,
            15'b0010000_0_0000_000, 15'b0001000_1_0001_000, 15'b0001100_0_0010_000,
            15'b0000010_0_0010_000, 15'b0000010_0_0010_000, 15'b0000010_0_0010_000,
            15'b0000010_0_0010_000, 15'b0000000_0_0010_001, 15'b0010000_0_0010_001};
    #2;
    chk("reset_outs", 32'(cur()), 32'(0));
    chk("reset_outs_n1", 32'(cur2()), 32'(0));
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("idle_s_ready", 32'(s_ready), 32'(0));

    sq.push_back(sv(1, 0, 0, 0, 0, 0, 0));
    sq.push_back(sv(1, 0, 0, 0, 1, 0, 0));
    for (int j = 0; j < 5; j++) begin
      sq.push_back(sv(0, 1, 0, 0, 0, 2 * j, j));
      sq.push_back(sv(0, 0, 1, 0, 1, 2 * j + 1, j));
      sq.push_back(sv(0, 0, 1, 1, 0, (2 * j + 2) % 10, j));
      rq.push_back({(j == 4) ? 1'b1 : 1'b0, 3'(j)});
    end
    s_valid = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("nrn0_seq%0d", i), 32'(cur()), 32'(tab[i]));
      if (i == 9) #1 m_ready = 1'b1;
    end

    for (int i = 0; i < 100 && !(m_valid && m_last); i++) @(negedge clk);
    chk("last_seen", 32'(m_valid && m_last), 32'(1));
    sq.push_back(sv(1, 0, 0, 0, 0, 0, 0));
    sq.push_back(sv(1, 0, 0, 0, 1, 0, 0));
    sq.push_back(sv(0, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("s_ready_back", 32'(s_ready), 32'(1));
    chk("hs_count", 32'(hs_cyc.size()), 32'(5));
    for (int i = 1; i < 5 && i < hs_cyc.size(); i++)
      chk($sformatf("hs_gap%0d", i), 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(5));

    for (int i = 0; i < 20 && !ld_bias; i++) @(negedge clk);
    chk("v2_ld", 32'(ld_bias), 32'(1));
    @(posedge clk);
    #1 chk("v2_mac2", 32'({en_acc, addr_w}), 32'(5'b10001));
    ignore = 1'b1;
    #1 reset = 1'b1;
    #1 chk("async_reset", 32'(cur()), 32'(0));
    s_valid = 1'b0;
    sq.delete();
    rq.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("restart_idle", 32'(s_ready), 32'(0));
    @(negedge clk);
    chk("restart_load", 32'(s_ready), 32'(1));

    for (int i = 0; i < 50 && !done2; i++) @(negedge clk);
    chk("small_done", 32'(done2), 32'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/layer_mac_sched.md
Name: layer_mac_sched

Overview:
- Sequencing controller for one fully-connected layer datapath: input-vector memory X, weight ROM W, bias ROM B and a single shared MAC accumulator with ReLU clamp.
- Accepts N input samples over a valid/ready slave handshake and writes them into X.
- Time-multiplexes the MAC across M neurons: issues ROM/memory addresses and accumulator controls, then presents each neuron result over a valid/ready master handshake.
- Sits between the layer wrapper and the datapath; drives control only, never data.

Parameters:
- M, 5, number of neurons (outputs per input vector), >=1
- N, 2, number of inputs per vector, >=1
- XW, max(1,$clog2(N)), X address width
- WW, max(1,$clog2(M*N)), W address width
- BW, max(1,$clog2(M)), B address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  controller accepting input samples
- m_valid  out  1  accumulator holds a finished neuron result
- m_ready  in  1  downstream accepts result
- m_last  out  1  with m_valid: result is neuron M-1
- wr_en_x  out  1  write data_in into X[addr_x]
- addr_x  out  XW  X address (write index in LOAD_X, read index in MAC)
- addr_w  out  WW  weight ROM address
- addr_b  out  BW  bias ROM address
- ld_bias  out  1  accumulator <= bias ROM output
- en_acc  out  1  accumulator <= acc + w*x
- en_relu  out  1  with en_acc: clamp result to 0 if negative

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- On reset:
  - state = IDLE; counters j, k and the W pointer are 0.
  - All outputs are 0, including s_ready, m_valid and the addresses.
- Datapath timing: X, W and B have registered reads with 1-cycle latency. Control strobes therefore follow the address issue by one cycle.
- Decoded outputs: s_ready = (state==LOAD_X); m_valid = (state==OUTPUT); wr_en_x = s_valid & s_ready.
- IDLE: lasts 1 cycle, then goes to LOAD_X.
- LOAD_X:
  - addr_x = write count k.
  - Each handshake increments k.
  - On the handshake with k==N-1: k<=0, go to BIAS.
  - s_valid with s_ready low is ignored; no write occurs.
- BIAS: lasts 1 cycle; addr_b = j; go to MAC with k=0.
- MAC:
  - Lasts N cycles.
  - Issue addr_x = k and addr_w = W pointer, then increment the pointer.
  - ld_bias = 1 in the first MAC cycle, i.e. the cycle after BIAS.
  - en_acc = 1 in every MAC cycle except the first.
  - After k==N-1, go to DRAIN.
- DRAIN: lasts 1 cycle; en_acc = 1 and en_relu = 1; go to OUTPUT.
- OUTPUT:
  - m_valid = 1; m_last = (j==M-1).
  - All strobes are 0 and all addresses hold.
  - Stay in OUTPUT until m_ready.
  - On the handshake:
    - If j==M-1: j<=0, W pointer <=0, go to LOAD_X.
    - Otherwise: j<=j+1, go to BIAS.
- Latency per neuron is N+3 cycles when m_ready is held high.
- Boundaries:
  - N==1: MAC lasts one cycle, with ld_bias only; DRAIN performs the single accumulate.
  - M==1: m_last is asserted on every result.
  - m_ready high before m_valid has no effect.
  - Back-to-back vectors: s_ready reasserts the cycle after the final output handshake.
  - Reset asserted mid-operation: all outputs drop immediately (asynchronously); the sequence restarts from IDLE.
- Width rules: the W pointer counts 0..M*N-1, then wraps to 0. Counters never exceed their limit, so no out-of-range addresses are ever issued.

Decomposition:
- Package layer_mac_sched_pkg:
  - state enum {IDLE, LOAD_X, BIAS, MAC, DRAIN, OUTPUT}
  - width helper function
- Sub-module layer_mac_sched_cnt:
  - modulo-LIMIT counter with en and clr; provides a wrap flag.
  - Instantiated for k (inputs) and j (neurons).
  - The W pointer is a separate plain counter.

Test Plan:
- Reset: assert reset mid-cycle while in MAC -> all outputs 0 before the next edge; after release, 1 IDLE cycle, then s_ready=1.
- Load, M=5 N=2, s_valid held high -> wr_en_x in 2 consecutive cycles with addr_x 0 then 1; s_ready=0 the following cycle.
- Neuron 0 sequence, in consecutive cycles:
  - BIAS: addr_b=0.
  - MAC 1: ld_bias=1, addr_w=0, addr_x=0.
  - MAC 2: en_acc=1, addr_w=1, addr_x=1.
  - DRAIN: en_acc=1, en_relu=1.
  - OUTPUT: m_valid=1, m_last=0.
- Backpressure: m_ready low 4 cycles in OUTPUT -> m_valid held 4 cycles, addresses stable, no strobes; after the handshake, BIAS with addr_b=1, and the next issue uses addr_w=2.
- Full vector, m_ready=1 -> 5 results, each 5 cycles apart; m_last only on the 5th; addr_w issues 0..9 in order; s_ready returns the cycle after the 5th handshake.
- s_valid=1 throughout BIAS/MAC/OUTPUT -> wr_en_x stays 0. With N=1, M=1: ld_bias, then DRAIN accumulate, then m_valid with m_last=1.
